// File: rtl/serial_parity_pkg.sv
// Shared definitions for the nibble-plus-parity receive path.
//   state_t / IDLE..WAIT_IDLE : receiver FSM encoding
//   FRAME_BITS                : line samples per frame at the default width
//   even_parity_ok()          : true when data bits plus parity bit have even weight
package serial_parity_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE      = 3'd0;
   localparam state_t DATA      = 3'd1;
   localparam state_t PARITY    = 3'd2;
   localparam state_t STOP      = 3'd3;
   localparam state_t WAIT_IDLE = 3'd4;

   localparam int unsigned DEFAULT_DATA_W = 4;
   // start + data + parity + stop
   localparam int unsigned FRAME_BITS     = DEFAULT_DATA_W + 3;
   // Widest data word the parity helper accepts; callers zero-extend.
   localparam int unsigned MAX_DATA_W     = 32;

   function automatic logic even_parity_ok(input logic [MAX_DATA_W-1:0] data, input logic p);
      return (^data) == p;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   inc   : add one this cycle unless already at all-ones
//   count : current value
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receive end of the nibble-plus-parity link. Deserialises
// start(0) / DATA_W data bits MSB first / parity / stop(1) frames from a
// one-bit line sampled on bit_en, and reports data plus parity/framing errors.
//   clk         : clock, rising edge
//   reset       : synchronous active-high clear, overrides bit_en
//   bit_en      : sample strobe for rx_bit
//   rx_bit      : serial line, idles high
//   data        : last received data word, held until the next frame
//   valid       : one-cycle pulse the cycle after the stop sample
//   parity_err  : parity mismatch on the last frame
//   frame_err   : stop bit was low on the last frame
//   frame_count : frames completed, saturating
//   error_count : frames with either error, saturating
module serial_parity_checker
   import serial_parity_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_en,
   input  logic              rx_bit,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_count,
   output logic [CNT_W-1:0]  error_count
);

   localparam int unsigned    BCW      = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;

   logic [DATA_W-1:0] data_q;
   logic              valid_q, perr_q, ferr_q;

   logic              frame_done;
   logic              perr_new, ferr_new;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      frame_done = 1'b0;
      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!rx_bit) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d    = shift_q << 1;
               shift_d[0] = rx_bit;
               bit_cnt_d  = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = rx_bit;
               state_d = STOP;
            end
            STOP: begin
               frame_done = 1'b1;
               // A low stop bit must see the line return high before the next start.
               state_d    = rx_bit ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
               if (rx_bit) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign perr_new = !even_parity_ok(MAX_DATA_W'(shift_q), par_q);
   assign ferr_new = ~rx_bit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         // Not gated by bit_en so the pulse always lasts one clock.
         valid_q   <= frame_done;
         if (frame_done) begin
            data_q <= shift_q;
            perr_q <= perr_new;
            ferr_q <= ferr_new;
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_frame_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (frame_done),
      .count(frame_count)
   );

   sat_counter #(
      .W(CNT_W)
   ) u_error_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (frame_done & (perr_new | ferr_new)),
      .count(error_count)
   );

   assign data       = data_q;
   assign valid      = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;

endmodule
